// File: rtl/back_fanout.sv
// back_fanout: two-stage pipeline fanning an 18-road return word out to a 28-cell back-layer enable mask
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   ret_in     18-bit road-return hit word, bit i = road i
//   in_valid   ret_in is valid
//   in_ready   block accepts ret_in this cycle
//   back_mask  28-bit back-cell enable mask, bit j = back cell j
//   hit_cnt    popcount of the ret word that produced back_mask
//   out_valid  back_mask/hit_cnt are valid
//   out_ready  downstream accepts the output
//   evt_cnt    saturating count of output transfers since reset
// Parameters: CNT_W (evt_cnt width), DROP_EMPTY (1 = swallow all-zero words)
// Macro: BACK_FANOUT_WIDE_EN widens every road window by one cell on each side
module back_fanout #(
   parameter int CNT_W      = 16,
   parameter bit DROP_EMPTY = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [17:0]      ret_in,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [27:0]      back_mask,
   output logic [4:0]       hit_cnt,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CNT_W-1:0] evt_cnt
);
`ifdef BACK_FANOUT_WIDE_EN
   localparam int WD = 1;
`else
   localparam int WD = 0;
`endif
   localparam int LO [18] = '{1, 2, 3, 5, 6, 7, 9, 10, 12, 13, 14, 16, 17, 18, 20, 21, 22, 24};
   localparam int HI [18] = '{3, 5, 6, 7, 9, 10, 11, 13, 14, 15, 17, 18, 20, 21, 22, 24, 25, 26};
   logic        a_valid, b_valid, a_drop, a_adv, a_take, b_adv, b_load;
   logic [17:0] a_ret;
   logic [27:0] mask_c;
   logic [4:0]  hit_c;
   // an empty word in stage A retires on its own without needing room in stage B
   assign a_drop    = DROP_EMPTY & ~|a_ret;
   assign b_adv     = ~b_valid | out_ready;
   assign a_adv     = a_valid & (a_drop | b_adv);
   assign a_take    = ~a_valid | a_adv;
   assign b_load    = b_adv & a_valid & ~a_drop;
   assign in_ready  = rst_n & a_take;
   assign out_valid = b_valid;
   always_comb begin
      mask_c = '0;
      hit_c  = '0;
      for (int i = 0; i < 18; i++) begin
         hit_c = hit_c + {4'b0, a_ret[i]};
         for (int j = 0; j < 28; j++)
            if (j >= LO[i] - WD && j <= HI[i] + WD) mask_c[j] = mask_c[j] | a_ret[i];
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_valid   <= 1'b0;
         a_ret     <= '0;
         b_valid   <= 1'b0;
         back_mask <= '0;
         hit_cnt   <= '0;
         evt_cnt   <= '0;
      end else begin
         if (a_take) a_valid <= in_valid;
         if (a_take & in_valid) a_ret <= ret_in;
         if (b_adv) b_valid <= a_valid & ~a_drop;
         if (b_load) begin
            back_mask <= mask_c;
            hit_cnt   <= hit_c;
         end
         if (b_valid & out_ready & ~&evt_cnt) evt_cnt <= evt_cnt + 1'b1;
      end
   end
endmodule

// File: tb/tb_back_fanout.sv
// tb_back_fanout: directed self-checking bench for back_fanout (default, DROP_EMPTY=1 and CNT_W=4 instances)
module tb_back_fanout;
  logic        clk = 1'b0;
  logic        rst_n, in_valid, out_ready;
  logic [17:0] ret_in;
  logic        rdy0, rdy1, rdy2, ov0, ov1, ov2;
  logic [27:0] m0, m1, m2, mk1;
  logic [4:0]  h0, h1, h2;
  logic [15:0] e0, e1;
  logic [3:0]  e2;
  int          checks = 0, errors = 0;
  int          cnt0, cnt1, idx, got, stale;
  logic [17:0] dw [3] = '{18'h0, 18'h2, 18'h0};
  logic [17:0] sw [5] = '{18'h4, 18'h8, 18'h10, 18'h20, 18'h40};
  logic [27:0] road [18] = '{28'h000000E, 28'h000003C, 28'h0000078, 28'h00000E0, 28'h00003C0, 28'h0000780,
                             28'h0000E00, 28'h0003C00, 28'h0007000, 28'h000E000, 28'h003C000, 28'h0070000,
                             28'h01E0000, 28'h03C0000, 28'h0700000, 28'h1E00000, 28'h3C00000, 28'h7000000};
  always #5 clk = ~clk;
  back_fanout u0 (.clk(clk), .rst_n(rst_n), .ret_in(ret_in), .in_valid(in_valid), .in_ready(rdy0),
                  .back_mask(m0), .hit_cnt(h0), .out_valid(ov0), .out_ready(out_ready), .evt_cnt(e0));
  back_fanout #(.DROP_EMPTY(1'b1)) u1 (.clk(clk), .rst_n(rst_n), .ret_in(ret_in), .in_valid(in_valid), .in_ready(rdy1),
                  .back_mask(m1), .hit_cnt(h1), .out_valid(ov1), .out_ready(out_ready), .evt_cnt(e1));
  back_fanout #(.CNT_W(4)) u2 (.clk(clk), .rst_n(rst_n), .ret_in(ret_in), .in_valid(in_valid), .in_ready(rdy2),
                  .back_mask(m2), .hit_cnt(h2), .out_valid(ov2), .out_ready(out_ready), .evt_cnt(e2));
  function automatic logic [27:0] wm(input logic [27:0] n);
`ifdef BACK_FANOUT_WIDE_EN
    return n | (n << 1) | (n >> 1);
`else
    return n;
`endif
  endfunction
  task automatic chk(input string tag, input bit ok, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic send(input logic [17:0] w, input logic [27:0] em, input logic [4:0] eh, input string tag);
    in_valid = 1'b1;
    ret_in   = w;
    step;
    in_valid = 1'b0;
    chk({tag, "_early"}, ov0 === 1'b0, ov0, 1'b0);
    step;
    chk({tag, "_valid"}, ov0 === 1'b1, ov0, 1'b1);
    chk({tag, "_mask"}, m0 === em, m0, em);
    chk({tag, "_hit"}, h0 === eh, h0, eh);
    step;
  endtask
  initial begin
    #200000;
    errors++;
    $error("FAIL watchdog expired");
    $finish;
  end
  initial begin
    rst_n = 1'b1; in_valid = 1'b0; ret_in = '0; out_ready = 1'b1;
    #1 rst_n = 1'b0;
    #12;
    chk("rst_in_ready", rdy0 === 1'b0, rdy0, 1'b0);
    chk("rst_out_valid", ov0 === 1'b0, ov0, 1'b0);
    chk("rst_evt", e0 === 16'h0, e0, 16'h0);
    chk("rst_mask", m0 === 28'h0, m0, 28'h0);
    chk("rst_hit", h0 === 5'h0, h0, 5'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", rdy0 === 1'b1, rdy0, 1'b1);
    send(18'h00001, wm(28'h000000E), 5'd1, "r0");
    chk("r0_evt", e0 === 16'd1, e0, 16'd1);
    cnt0 = 0; cnt1 = 0; mk1 = '0;
    for (int k = 0; k < 7; k++) begin
      in_valid = k < 3;
      ret_in   = k < 3 ? dw[k] : 18'h0;
      step;
      if (ov0) cnt0++;
      if (ov1) begin cnt1++; mk1 = m1; end
    end
    in_valid = 1'b0;
    step;
    chk("drop0_count", cnt0 === 3, cnt0, 3);
    chk("drop1_count", cnt1 === 1, cnt1, 1);
    chk("drop1_mask", mk1 === wm(28'h000003C), mk1, wm(28'h000003C));
    chk("drop0_evt", e0 === 16'd4, e0, 16'd4);
    chk("drop1_evt", e1 === 16'd2, e1, 16'd2);
    chk("drop2_evt", e2 === 4'd4, e2, 4'd4);
    for (int k = 0; k < 19; k++) begin
      in_valid = k < 18;
      ret_in   = k < 18 ? 18'(1) << k : 18'h0;
      step;
      if (k >= 1) begin
        chk($sformatf("sweep%0d_valid", k - 1), ov0 === 1'b1, ov0, 1'b1);
        chk($sformatf("sweep%0d_mask", k - 1), m0 === wm(road[k - 1]), m0, wm(road[k - 1]));
        chk($sformatf("sweep%0d_hit", k - 1), h0 === 5'd1, h0, 5'd1);
      end
    end
    step;
    chk("sweep_evt0", e0 === 16'd22, e0, 16'd22);
    chk("sweep_evt1", e1 === 16'd20, e1, 16'd20);
    chk("sat_evt2", e2 === 4'hF, e2, 4'hF);
    send(18'h3FFFF, wm(28'h7FFFFFE), 5'd18, "all");
    send(18'h15555, wm(28'h3FFFFFE), 5'd9, "alt");
    chk("alt_evt", e0 === 16'd24, e0, 16'd24);
    out_ready = 1'b0; in_valid = 1'b1; ret_in = sw[0];
    #1 chk("stall_rdy_w0", rdy0 === 1'b1, rdy0, 1'b1);
    step;
    ret_in = sw[1];
    #1 chk("stall_rdy_w1", rdy0 === 1'b1, rdy0, 1'b1);
    step;
    ret_in = sw[2];
    #1 chk("stall_rdy_full", rdy0 === 1'b0, rdy0, 1'b0);
    chk("stall_valid", ov0 === 1'b1, ov0, 1'b1);
    chk("stall_mask_a", m0 === wm(road[2]), m0, wm(road[2]));
    step;
    #1 chk("stall_rdy_hold", rdy0 === 1'b0, rdy0, 1'b0);
    chk("stall_mask_b", m0 === wm(road[2]), m0, wm(road[2]));
    step;
    #1 chk("stall_mask_c", m0 === wm(road[2]), m0, wm(road[2]));
    chk("stall_hit", h0 === 5'd1, h0, 5'd1);
    out_ready = 1'b1;
    idx = 2; got = 0;
    for (int c = 0; c < 20 && got < 5; c++) begin
      in_valid = idx < 5;
      ret_in   = idx < 5 ? sw[idx] : 18'h0;
      #1;
      if (ov0) begin
        chk($sformatf("order%0d_mask", got), m0 === wm(road[2 + got]), m0, wm(road[2 + got]));
        got++;
      end
      if (in_valid && rdy0) idx++;
      step;
    end
    in_valid = 1'b0;
    if (got < 5) begin
      errors++;
      $error("FAIL stream wait expired got=%0d", got);
    end
    chk("stream_got", got === 5, got, 5);
    chk("stream_sent", idx === 5, idx, 5);
    chk("stream_evt", e0 === 16'd29, e0, 16'd29);
    out_ready = 1'b0; in_valid = 1'b1; ret_in = 18'h00080;
    step;
    step;
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", ov0 === 1'b0, ov0, 1'b0);
    chk("mid_rst_evt0", e0 === 16'h0, e0, 16'h0);
    chk("mid_rst_evt2", e2 === 4'h0, e2, 4'h0);
    chk("mid_rst_mask", m0 === 28'h0, m0, 28'h0);
    chk("mid_rst_rdy", rdy0 === 1'b0, rdy0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1; stale = 0;
    for (int c = 0; c < 5; c++) begin
      #1 if (ov0 | ov1 | ov2) stale++;
      step;
    end
    chk("no_stale", stale === 0, stale, 0);
    chk("post_rst_evt", e0 === 16'h0, e0, 16'h0);
    if (errors != 0) $error("FAIL %0d of %0d checks", errors, checks);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/back_fanout.md
BACK_FANOUT -- requirements
Module: back_fanout

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16: width of the forwarded-event counter.
REQ-002 The block SHALL have parameter DROP_EMPTY, default 0: when 1, the block consumes all-zero ret words and does not forward them.
REQ-003 clk  input  1  single clock; all state is updated on the rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 ret_in  input  18  road-return hit word, bit i = road i.
REQ-006 in_valid  input  1  ret_in is valid.
REQ-007 in_ready  output  1  the block accepts ret_in this cycle.
REQ-008 back_mask  output  28  back-layer cell enable mask, bit j = back cell j.
REQ-009 hit_cnt  output  5  number of set bits in the ret word that produced back_mask (0..18).
REQ-010 out_valid  output  1  back_mask and hit_cnt are valid.
REQ-011 out_ready  input  1  the downstream stage accepts the output.
REQ-012 evt_cnt  output  CNT_W  count of output transfers since reset; saturates at all-ones.

Function
REQ-013 Input transfer: in_valid & in_ready on a rising edge; output transfer: out_valid & out_ready on a rising edge.
REQ-014 Narrow window lo..hi of each road, indexed by road 0..17: 1-3, 2-5, 3-6, 5-7, 6-9, 7-10, 9-11, 10-13, 12-14, 13-15, 14-17, 16-18, 17-20, 18-21, 20-22, 21-24, 22-25, 24-26.
REQ-015 back_mask[j] SHALL equal the OR of ret[i] over every road i whose active window contains j.
REQ-016 Pipeline: stage A registers the accepted ret word; stage B registers back_mask and hit_cnt computed from stage A.
REQ-017 Latency: with out_ready held high, out_valid SHALL rise 2 cycles after the input transfer edge; throughput is one word per cycle.
REQ-018 Backpressure: each stage SHALL advance when it is empty or its downstream stage advances in the same cycle.
REQ-019 in_ready = !A_valid | A_advances; the block has no combinational path from in_valid to out_valid.
REQ-020 While out_valid=1 and out_ready=0, back_mask and hit_cnt SHALL hold stable, and the block SHALL lose or duplicate no word.
REQ-021 With DROP_EMPTY=1, a ret word of 0 SHALL complete its input transfer, never reach stage B, and leave evt_cnt unchanged.
REQ-022 With DROP_EMPTY=0, a ret word of 0 SHALL be forwarded with back_mask=0 and hit_cnt=0.
REQ-023 evt_cnt SHALL increment by 1 on each output transfer and SHALL stick at 2^CNT_W-1 without wrapping.
REQ-024 A simultaneous input transfer and output transfer on a full pipeline SHALL shift both stages in one cycle.
REQ-025 Ordering: output words SHALL leave in input-transfer order.

Reset
REQ-026 While rst_n=0, all stage valids, out_valid, back_mask, hit_cnt and evt_cnt SHALL be 0 asynchronously.
REQ-027 in_ready SHALL be 0 while rst_n=0 and SHALL be 1 on the first clock edge after rst_n deasserts.
REQ-028 Reset asserted mid-operation SHALL discard every in-flight word; no partial output SHALL appear after release.

Configuration
REQ-029 Macro BACK_FANOUT_WIDE_EN: when defined, every road window widens to lo-1..hi+1 (road 0 = 0-4, road 17 = 23-27).
REQ-030 When BACK_FANOUT_WIDE_EN is not defined, the narrow windows apply and back_mask[0] and back_mask[27] SHALL be constant 0.
REQ-031 Latency, handshake and counter behaviour SHALL be identical in both configurations.

Verification
REQ-032 Narrow, out_ready=1, ret_in=18'h00001 -> 2 cycles later back_mask=28'h000000E, hit_cnt=1, evt_cnt=1.
REQ-033 Narrow, ret_in=18'h20000 -> back_mask=28'h7000000; ret_in=18'h3FFFF -> back_mask=28'h7FFFFFE, hit_cnt=18.
REQ-034 Wide, ret_in=18'h00001 -> back_mask=28'h000001F; ret_in=18'h3FFFF -> back_mask=28'hFFFFFFF.
REQ-035 Stream 5 distinct words with out_ready=0 for 4 cycles, then 1 -> in_ready drops after 2 accepted words, all 5 outputs appear in order, output stable while stalled, evt_cnt=5.
REQ-036 DROP_EMPTY=1, inputs 0, 18'h00002, 0 -> exactly one output, back_mask=28'h000003C, evt_cnt=1; with DROP_EMPTY=0 the same inputs give three outputs.
REQ-037 CNT_W=4, 20 output transfers -> evt_cnt=4'hF; rst_n pulse mid-stream -> out_valid=0 and evt_cnt=0 immediately, no stale word after release.
